// File: rtl/sw_debounce.sv
// sw_debounce - conditions raw slide-switch pins for the switch PIO in_port.
//
// Each bit goes through a 2-flop synchronizer and then an independent
// stability counter. A change is accepted only after the synchronized level
// has differed from the debounced level for DEBOUNCE_CYCLES consecutive
// cycles. Accepted changes also produce one-cycle rise/fall pulses.
//
// Ports:
//   clk      system clock (PIO domain)
//   reset    synchronous, active-high reset
//   sw_raw   [WIDTH] asynchronous switch pins
//   sw_db    [WIDTH] debounced levels, registered (drives PIO in_port)
//   rise     [WIDTH] one-cycle pulse when sw_db[i] goes 0->1
//   fall     [WIDTH] one-cycle pulse when sw_db[i] goes 1->0
//   changed  OR of rise|fall, registered in the same cycle as them

// Per-bit synchronizer + stability counter.
module sw_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic pulse_nxt   // high when this edge commits a change
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;

    // PENDING when the synchronized level disagrees with the debounced one;
    // the state is implied by this compare rather than stored.
    always_comb begin
        mismatch  = (s2 != db);
        pulse_nxt = mismatch && (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            db   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (!mismatch) begin
                // Any agreeing cycle restarts the count: this is what
                // rejects bounce shorter than DEBOUNCE_CYCLES.
                cnt  <= '0;
                rise <= 1'b0;
                fall <= 1'b0;
            end else if (cnt == LAST) begin
                db   <= s2;
                cnt  <= '0;
                rise <= s2;
                fall <= ~s2;
            end else begin
                cnt  <= cnt + 1'b1;
                rise <= 1'b0;
                fall <= 1'b0;
            end
        end
    end
endmodule

module sw_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);
    logic [WIDTH-1:0] pulse_nxt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .raw       (sw_raw[i]),
            .db        (sw_db[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .pulse_nxt (pulse_nxt[i])
        );
    end

    // Built from the per-bit commit terms so it lands in the same cycle as
    // rise/fall instead of one cycle behind them.
    always_ff @(posedge clk) begin
        if (reset) changed <= 1'b0;
        else       changed <= |pulse_nxt;
    end
endmodule
